// File: rtl/reg_read_pkg.sv
// reg_read_pkg: shared constants and types for the register read responder.
//   DW_DEFAULT    - default register entry width
//   AW_DEFAULT    - default address width
//   DEPTH_DEFAULT - default number of implemented entries
//   rd_state_t    - responder FSM state (IDLE: nothing held, RESP: response held)
package reg_read_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int AW_DEFAULT    = 3;
  localparam int DEPTH_DEFAULT = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/rd_rsp_buf.sv
// rd_rsp_buf: single-entry holding register for a read response.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   load                 - capture load_data/load_err and mark the entry valid
//   consume              - entry handed off this cycle; clears valid unless
//                          a new load arrives in the same cycle
//   load_data, load_err  - response payload to capture
//   rsp_valid            - entry holds a response
//   rsp_data, rsp_err    - held payload; only changes on load, so it stays
//                          stable while the consumer stalls
module rd_rsp_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          consume,
  input  logic [DW-1:0] load_data,
  input  logic          load_err,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      err_d   = load_err;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: rtl/reg_read_responder.sv
// reg_read_responder: small register bank with a valid/ready read port.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   we, waddr, wdata          - bank write port (writes to unmapped addresses dropped)
//   rd_req_valid/ready, rd_addr - read request handshake
//   rd_rsp_valid/ready        - read response handshake
//   rd_rsp_data, rd_rsp_err   - response payload; err flags an unmapped address
//   rd_count                  - completed responses, modulo 256
// A request accepted at an edge produces a response the next cycle. While a
// response is held, a new request is only accepted in the same cycle the held
// one is consumed, giving one response per cycle under continuous ready.
module reg_read_responder
  import reg_read_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_rsp_valid,
  input  logic          rd_rsp_ready,
  output logic [DW-1:0] rd_rsp_data,
  output logic          rd_rsp_err,
  output logic [7:0]    rd_count
);

  rd_state_t     state_q, state_d;
  logic [DW-1:0] bank_q [DEPTH];
  logic [DW-1:0] bank_d [DEPTH];
  logic [7:0]    rd_count_q, rd_count_d;

  logic          accept;
  logic          consume;
  logic          rd_mapped;
  logic [DW-1:0] rd_entry;
  logic [DW-1:0] load_data;

  // Bank write decode.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bank_d[i] = bank_q[i];
      if (we && (32'(waddr) == 32'(i))) begin
        bank_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // Handshake: state resets asynchronously to IDLE, so ready reads 1 in reset.
  assign rd_req_ready = (state_q == IDLE) || rd_rsp_ready;
  assign accept       = rd_req_valid && rd_req_ready;
  assign consume      = rd_rsp_valid && rd_rsp_ready;

  // Read mux with same-edge write forwarding; unmapped addresses return 0.
  assign rd_mapped = (32'(rd_addr) < 32'(DEPTH));

  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(rd_addr) == 32'(i)) begin
        rd_entry = bank_q[i];
      end
    end
  end

  always_comb begin
    load_data = '0;
    if (rd_mapped) begin
      load_data = (we && (waddr == rd_addr)) ? wdata : rd_entry;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: if (rd_rsp_ready) state_d = accept ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completed-response counter, wraps naturally at 8 bits.
  assign rd_count_d = rd_count_q + (consume ? 8'd1 : 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= 8'd0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;

  rd_rsp_buf #(
    .DW(DW)
  ) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .consume   (consume),
    .load_data (load_data),
    .load_err  (!rd_mapped),
    .rsp_valid (rd_rsp_valid),
    .rsp_data  (rd_rsp_data),
    .rsp_err   (rd_rsp_err)
  );

endmodule

// File: tb/tb_reg_read_responder.sv
module tb_reg_read_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       rd_req_valid;
  logic       rd_req_ready;
  logic [2:0] rd_addr;
  logic       rd_rsp_valid;
  logic       rd_rsp_ready;
  logic [7:0] rd_rsp_data;
  logic       rd_rsp_err;
  logic [7:0] rd_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus the single outstanding response.
  int   m_mem [8];
  bit   m_valid;
  int   m_data;
  bit   m_err;
  int   m_count;
  int   consumed_addrs [$];
  int   held_addr;

  always #5 clk = ~clk;

  reg_read_responder dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .rd_count     (rd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
    m_valid = 0;
    m_data  = 0;
    m_err   = 0;
    m_count = 0;
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0;
    rd_req_valid = 0; rd_addr = 0; rd_rsp_ready = 0;
  endtask

  // One clock cycle: check the combinational ready, advance the model by the
  // behavioural rules, take the edge, then compare registered outputs.
  task automatic tick();
    bit acc, cons;
    #1;
    chk("req_ready", {31'd0, rd_req_ready}, (!m_valid || rd_rsp_ready) ? 1 : 0);
    acc  = rd_req_valid && (!m_valid || rd_rsp_ready);
    cons = m_valid && rd_rsp_ready;
    if (cons) begin
      m_count = (m_count + 1) % 256;
      consumed_addrs.push_back(held_addr);
    end
    if (acc) begin
      held_addr = int'(rd_addr);
      if (rd_addr < 6) begin
        m_err  = 0;
        m_data = (we && waddr == rd_addr) ? int'(wdata) : m_mem[rd_addr];
      end else begin
        m_err  = 1;
        m_data = 0;
      end
      m_valid = 1;
    end else if (cons) begin
      m_valid = 0;
    end
    if (we && waddr < 6) m_mem[waddr] = int'(wdata);
    @(posedge clk);
    #1;
    chk("rsp_valid", {31'd0, rd_rsp_valid}, m_valid ? 1 : 0);
    if (m_valid) begin
      chk("rsp_data", {24'd0, rd_rsp_data}, m_data);
      chk("rsp_err", {31'd0, rd_rsp_err}, m_err ? 1 : 0);
    end
    chk("rd_count", {24'd0, rd_count}, m_count);
    $display("cyc we=%0d wa=%0d wd=%02h rv=%0d ra=%0d rr=%0d -> v=%0d d=%02h e=%0d cnt=%0d",
             we, waddr, wdata, rd_req_valid, rd_addr, rd_rsp_ready,
             rd_rsp_valid, rd_rsp_data, rd_rsp_err, rd_count);
  endtask

  task automatic do_write(input int a, input int d);
    idle_inputs();
    we = 1; waddr = 3'(a); wdata = 8'(d);
    tick();
    idle_inputs();
  endtask

  // Asynchronous reset pulse applied mid-cycle; outputs must clear without an edge.
  task automatic apply_reset();
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("rst_valid", {31'd0, rd_rsp_valid}, 0);
    chk("rst_count", {24'd0, rd_count}, 0);
    chk("rst_data", {24'd0, rd_rsp_data}, 0);
    chk("rst_err", {31'd0, rd_rsp_err}, 0);
    chk("rst_ready", {31'd0, rd_req_ready}, 1);
    // A request presented during reset must not be accepted.
    rd_req_valid = 1; rd_addr = 3'd2; rd_rsp_ready = 1;
    @(posedge clk);
    #1;
    chk("rst_noaccept", {31'd0, rd_rsp_valid}, 0);
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, rd_rsp_valid}, 0);
  endtask

  initial begin
    int t0;
    idle_inputs();
    rst = 0;
    held_addr = 0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Write 0xA5 to 2, read it back with ready high.
    do_write(2, 8'hA5);
    rd_req_valid = 1; rd_addr = 3'd2; rd_rsp_ready = 1;
    tick();
    chk("a5_data", {24'd0, rd_rsp_data}, 32'hA5);
    rd_req_valid = 0;
    tick();
    chk("a5_count", {24'd0, rd_count}, 1);

    // Unmapped reads, and a write to an unmapped address.
    rd_req_valid = 1; rd_addr = 3'd7; rd_rsp_ready = 1;
    tick();
    chk("a7_err", {31'd0, rd_rsp_err}, 1);
    chk("a7_data", {24'd0, rd_rsp_data}, 0);
    idle_inputs();
    rd_rsp_ready = 1;
    tick();
    do_write(6, 8'h5A);
    rd_req_valid = 1; rd_addr = 3'd6; rd_rsp_ready = 1;
    tick();
    chk("a6_err", {31'd0, rd_rsp_err}, 1);
    idle_inputs();
    rd_rsp_ready = 1;
    tick();

    // Stall with a write to the held address.
    do_write(1, 8'h3C);
    rd_req_valid = 1; rd_addr = 3'd1; rd_rsp_ready = 0;
    tick();
    t0 = m_count;
    for (int i = 0; i < 5; i++) begin
      we = 1; waddr = 3'd1; wdata = 8'hFF;
      rd_req_valid = 1; rd_addr = 3'd3; rd_rsp_ready = 0;
      tick();
      chk("stall_data", {24'd0, rd_rsp_data}, 32'h3C);
    end
    idle_inputs();
    rd_rsp_ready = 1;
    tick();
    chk("stall_release_count", {24'd0, rd_count}, (t0 + 1) % 256);

    // Same-edge write and read forwarding.
    we = 1; waddr = 3'd4; wdata = 8'h77;
    rd_req_valid = 1; rd_addr = 3'd4; rd_rsp_ready = 1;
    tick();
    chk("fwd_data", {24'd0, rd_rsp_data}, 32'h77);
    idle_inputs();
    rd_rsp_ready = 1;
    tick();

    // Back-to-back reads of 0..5 (also confirms entries survived the write to 6).
    consumed_addrs.delete();
    for (int a = 0; a < 6; a++) begin
      rd_req_valid = 1; rd_addr = 3'(a); rd_rsp_ready = 1;
      tick();
      chk("b2b_ready", {31'd0, rd_rsp_valid}, 1);
    end
    idle_inputs();
    rd_rsp_ready = 1;
    tick();
    chk("b2b_n", consumed_addrs.size(), 6);
    for (int a = 0; a < 6 && a < consumed_addrs.size(); a++)
      chk("b2b_order", consumed_addrs[a], a);

    // 256 responses wrap the counter.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      rd_req_valid = 1; rd_addr = 3'($urandom_range(0, 7)); rd_rsp_ready = 1;
      tick();
    end
    idle_inputs();
    rd_rsp_ready = 1;
    tick();
    chk("wrap_count", {24'd0, rd_count}, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      we           = ($urandom_range(0, 9) < 3);
      waddr        = 3'($urandom_range(0, 7));
      wdata        = 8'($urandom);
      rd_req_valid = ($urandom_range(0, 9) < 6);
      rd_addr      = 3'($urandom_range(0, 7));
      rd_rsp_ready = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Reset while a response is held.
    idle_inputs();
    rd_req_valid = 1; rd_addr = 3'd0; rd_rsp_ready = 0;
    tick();
    chk("pre_rst_held", {31'd0, rd_rsp_valid}, 1);
    idle_inputs();
    apply_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_read_responder.md
REG_READ_RESPONDER -- requirements
Module: reg_read_responder

Interface
REQ-001 Parameter DW, default 8, data width of each register entry.
REQ-002 Parameter AW, default 3, address width.
REQ-003 Parameter DEPTH, default 6, number of implemented entries; addresses DEPTH..2**AW-1 are unmapped.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 we  input  1  write enable for the register bank.
REQ-007 waddr  input  AW  write address.
REQ-008 wdata  input  DW  write data.
REQ-009 rd_req_valid  input  1  read request present.
REQ-010 rd_req_ready  output  1  responder can accept a request this cycle.
REQ-011 rd_addr  input  AW  read address, qualified by rd_req_valid.
REQ-012 rd_rsp_valid  output  1  response present.
REQ-013 rd_rsp_ready  input  1  consumer accepts the response this cycle.
REQ-014 rd_rsp_data  output  DW  read data, qualified by rd_rsp_valid.
REQ-015 rd_rsp_err  output  1  response is for an unmapped address, qualified by rd_rsp_valid.
REQ-016 rd_count  output  8  number of completed responses, modulo 256.

Function
REQ-017 A write with we=1 and waddr<DEPTH SHALL update the entry at the rising edge; a write with waddr>=DEPTH SHALL be ignored.
REQ-018 The FSM SHALL have two states, IDLE (no response held) and RESP (response held).
REQ-019 rd_req_ready SHALL be 1 in IDLE, and in RESP only when rd_rsp_ready=1; it SHALL be combinational from state and rd_rsp_ready.
REQ-020 A request is accepted when rd_req_valid and rd_req_ready are both 1 at a rising edge; rd_rsp_valid SHALL go high in the next cycle (latency 1).
REQ-021 Accepted in IDLE: next state is RESP.
REQ-022 RESP with rd_rsp_ready=1 and no new request: next state is IDLE.
REQ-023 RESP with rd_rsp_ready=1 and a new request accepted: state remains RESP, and the new response is presented in the next cycle, giving one response per cycle.
REQ-024 While rd_rsp_valid=1 and rd_rsp_ready=0, rd_rsp_data and rd_rsp_err SHALL hold stable, and later writes SHALL NOT alter them.
REQ-025 Response data SHALL be the entry value captured at the acceptance edge.
REQ-026 If a write to the same mapped address coincides with acceptance, the response SHALL carry the new wdata (write-forwarding).
REQ-027 For rd_addr>=DEPTH, the response SHALL have rd_rsp_err=1 and rd_rsp_data=0.
REQ-028 For mapped addresses, rd_rsp_err SHALL be 0.
REQ-029 rd_count SHALL increment by 1 on every edge with rd_rsp_valid and rd_rsp_ready both 1, including error responses.
REQ-030 rd_count SHALL wrap from 255 to 0.
REQ-031 rd_rsp_ready=1 while rd_rsp_valid=0 SHALL have no effect.

Reset
REQ-032 On rst, the following SHALL be set immediately, without waiting for clk: all entries 0, state IDLE, rd_rsp_valid 0, rd_rsp_data 0, rd_rsp_err 0, rd_count 0.
REQ-033 Reset asserted while in RESP SHALL discard the held response without counting it.
REQ-034 During reset, rd_req_ready SHALL read 1.
REQ-035 No request SHALL be accepted at any edge where rst=1.

Structure
REQ-036 Package reg_read_pkg SHALL hold the default DW, AW and DEPTH constants and the state enum type {IDLE, RESP}.
REQ-037 The response holding register (data, err, valid, with a load/hold control) SHALL be a sub-module rd_rsp_buf.
REQ-038 The bank, write decode, forwarding, FSM and counter SHALL live in the top module.

Verification
REQ-039 Write 0xA5 to address 2, then read address 2 with rd_rsp_ready=1 -> rd_rsp_valid one cycle after acceptance, data 0xA5, err 0, rd_count=1.
REQ-040 Read address 7 -> rd_rsp_err=1, data 0x00. Write to address 6, then read address 6 -> err 1; entries 0-5 unchanged.
REQ-041 Hold rd_rsp_ready=0 for 5 cycles after a read of address 1 (value 0x3C) while writing 0xFF to address 1 -> data stays 0x3C and rd_req_ready=0 throughout; on release, rd_count increments once.
REQ-042 Same-edge write 0x77 to address 4 and read of address 4 -> response 0x77.
REQ-043 Back-to-back reads of addresses 0..5 with rd_rsp_ready=1 -> 6 consecutive valid cycles in address order.
REQ-044 Complete 256 responses -> rd_count returns to 0.
REQ-045 Assert rst mid-RESP -> rd_rsp_valid drops immediately and rd_count reads 0.
